addition_subtraction: RTL and testbench

//  IEEE-754 single-precision floating-point adder/subtractor with one registered output stage.

---
 rtl/fp32_pkg.sv | 24 ++
 rtl/lzc24.sv | 13 +
 rtl/addition_subtraction.sv | 107 ++++++++++
 tb/tb_addition_subtraction.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 constants, field layout and unpack helper for the FP add/sub datapath.
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;

  function automatic fp32_t fp32_unpack(input logic [31:0] v);
    fp32_t f;
    f.sign = v[31];
    f.exp  = v[30:23];
    f.frac = v[22:0];
    return f;
  endfunction
endpackage

// File: rtl/lzc24.sv
// 24-bit leading-zero counter; an all-zero input reports 24.
module lzc24 (
  input  logic [23:0] in_i,
  output logic [4:0]  cnt_o
);
  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (in_i[i]) cnt_o = 5'(23 - i);
    end
  end
endmodule

// File: rtl/addition_subtraction.sv
// binary32 adder/subtractor, truncating, flush-to-zero, one registered output stage.
module addition_subtraction
  import fp32_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        Exception,
  output logic [31:0] Result
);
  fp32_t       ua, ub;
  logic        sb_eff;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [30:0] mag_a, mag_b;
  logic        a_big;
  logic        sx, sy;
  logic [7:0]  ex, ey, exp_diff;
  logic [23:0] man_x, man_y, man_y_al;
  logic [24:0] sum;
  logic [4:0]  lz;
  logic [22:0] norm_frac;
  logic [9:0]  norm_exp;
  logic [31:0] result_d, result_q;
  logic        exc_d, exc_q;

  assign ua     = fp32_unpack(a_operand);
  assign ub     = fp32_unpack(b_operand);
  assign sb_eff = ub.sign ^ AddBar_Sub;

  assign a_nan = (ua.exp == 8'hFF) && (ua.frac != '0);
  assign b_nan = (ub.exp == 8'hFF) && (ub.frac != '0);
  assign a_inf = (ua.exp == 8'hFF) && (ua.frac == '0);
  assign b_inf = (ub.exp == 8'hFF) && (ub.frac == '0);

  // Denormals are flushed before the magnitude compare so they order as zero.
  assign mag_a = (ua.exp == '0) ? 31'd0 : a_operand[30:0];
  assign mag_b = (ub.exp == '0) ? 31'd0 : b_operand[30:0];
  assign a_big = (mag_a >= mag_b);

  assign sx    = a_big ? ua.sign : sb_eff;
  assign sy    = a_big ? sb_eff  : ua.sign;
  assign ex    = a_big ? ua.exp  : ub.exp;
  assign ey    = a_big ? ub.exp  : ua.exp;
  assign man_x = a_big ? ((ua.exp != '0) ? {1'b1, ua.frac} : 24'd0)
                       : ((ub.exp != '0) ? {1'b1, ub.frac} : 24'd0);
  assign man_y = a_big ? ((ub.exp != '0) ? {1'b1, ub.frac} : 24'd0)
                       : ((ua.exp != '0) ? {1'b1, ua.frac} : 24'd0);

  assign exp_diff = ex - ey;
  assign man_y_al = (exp_diff >= 8'd24) ? 24'd0 : (man_y >> exp_diff);
  assign sum      = (sx == sy) ? ({1'b0, man_x} + {1'b0, man_y_al})
                               : ({1'b0, man_x} - {1'b0, man_y_al});

  lzc24 u_lzc (
    .in_i  (sum[23:0]),
    .cnt_o (lz)
  );

  always_comb begin
    if (sum[24]) begin
      norm_frac = sum[23:1];
      norm_exp  = {2'b00, ex} + 10'd1;
    end else begin
      norm_frac = 23'(sum[23:0] << lz);
      norm_exp  = {2'b00, ex} - {5'b00000, lz};
    end
  end

  always_comb begin
    result_d = FP32_ZERO;
    exc_d    = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (ua.sign != sb_eff))) begin
      result_d = FP32_QNAN;
      exc_d    = 1'b1;
    end else if (a_inf) begin
      result_d = {ua.sign, FP32_POS_INF[30:0]};
      exc_d    = 1'b1;
    end else if (b_inf) begin
      result_d = {sb_eff, FP32_POS_INF[30:0]};
      exc_d    = 1'b1;
    end else if (sum == '0) begin
      result_d = FP32_ZERO;
    end else if (norm_exp[9] || (norm_exp == 10'd0)) begin
      result_d = FP32_ZERO;
    end else if (norm_exp >= 10'd255) begin
      result_d = {sx, FP32_POS_INF[30:0]};
      exc_d    = 1'b1;
    end else begin
      result_d = {sx, norm_exp[7:0], norm_frac};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      result_q <= FP32_ZERO;
      exc_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign Result    = result_q;
  assign Exception = exc_q;
endmodule

// File: tb/tb_addition_subtraction.sv
// Directed and streamed checks of the binary32 add/sub against hand values and a truncating model.
module tb_addition_subtraction;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] a_operand = '0;
  logic [31:0] b_operand = '0;
  logic        AddBar_Sub = 1'b0;
  logic        Exception;
  logic [31:0] Result;

  int vectors = 0;
  int miscompares = 0;

  addition_subtraction dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .a_operand  (a_operand),
    .b_operand  (b_operand),
    .AddBar_Sub (AddBar_Sub),
    .Exception  (Exception),
    .Result     (Result)
  );

  always #5 CLK = ~CLK;

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic s);
    a_operand  = a;
    b_operand  = b;
    AddBar_Sub = s;
    @(posedge CLK);
    #1;
  endtask

  // Independent truncating reference: aligned-away bits are lost before the add/sub.
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub);
    logic sa, sb, sx, sy;
    int ea, eb, ex, ey, e, d;
    longint ma, mb, mx, my, yal, s;
    logic [31:0] r;
    sa = a[31]; sb = b[31] ^ sub;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
        (ea == 255 && eb == 255 && sa != sb)) return {1'b1, 32'h7FC00000};
    if (ea == 255) return {1'b1, sa, 31'h7F800000};
    if (eb == 255) return {1'b1, sb, 31'h7F800000};
    ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
    mb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(b[22:0]);
    if (ea > eb || (ea == eb && ma >= mb)) begin
      sx = sa; sy = sb; ex = ea; ey = eb; mx = ma; my = mb;
    end else begin
      sx = sb; sy = sa; ex = eb; ey = ea; mx = mb; my = ma;
    end
    d = ex - ey;
    yal = (d >= 24) ? 0 : (my >> d);
    s = (sx == sy) ? mx + yal : mx - yal;
    if (s == 0) return 33'd0;
    e = ex;
    while (s >= (longint'(1) << 24)) begin s = s >> 1; e++; end
    while (s <  (longint'(1) << 23)) begin s = s << 1; e--; end
    if (e <= 0) return 33'd0;
    if (e >= 255) return {1'b1, sx, 31'h7F800000};
    r = {sx, 8'(e), 23'(s)};
    return {1'b0, r};
  endfunction

  task automatic test_reset();
    RESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(32'h3F800000, 32'h3F800000, 1'b0);
      vectors++;
      if ({Exception, Result} !== 33'd0) begin
        miscompares++;
        $display("FAIL reset[%0d]: got exc=%b res=%h, want exc=0 res=00000000", i, Exception, Result);
      end
    end
    RESET = 1'b0;
    apply(32'h3F800000, 32'h3F800000, 1'b0);
    vectors++;
    if ({Exception, Result} !== {1'b0, 32'h40000000}) begin
      miscompares++;
      $display("FAIL reset_release: got exc=%b res=%h, want exc=0 res=40000000", Exception, Result);
    end
  endtask

  task automatic test_arith();
    logic [31:0] av [9] = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h3F800000, 32'h00000000,
                            32'h00000000, 32'h3F800001, 32'h00C00000, 32'h00000001};
    logic [31:0] bv [9] = '{32'h40000000, 32'h3F800000, 32'hBFC00000, 32'h33800000, 32'hC1200000,
                            32'h3F800000, 32'h3F800000, 32'h00800000, 32'h3F800000};
    logic        sv [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] rv [9] = '{32'h40400000, 32'h40000000, 32'h00000000, 32'h3F800000, 32'hC1200000,
                            32'hBF800000, 32'h34000000, 32'h00000000, 32'h3F800000};
    for (int i = 0; i < 9; i++) begin
      apply(av[i], bv[i], sv[i]);
      vectors++;
      if ({Exception, Result} !== {1'b0, rv[i]}) begin
        miscompares++;
        $display("FAIL arith[%0d] %h op%b %h: got exc=%b res=%h, want exc=0 res=%h",
                 i, av[i], sv[i], bv[i], Exception, Result, rv[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] av [6] = '{32'h7F800000, 32'h7F800000, 32'h7F7FFFFF, 32'h7FC00001,
                            32'h3F800000, 32'hFF800000};
    logic [31:0] bv [6] = '{32'h3F800000, 32'h7F800000, 32'h7F7FFFFF, 32'h3F800000,
                            32'h7F800000, 32'hFF800000};
    logic        sv [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] rv [6] = '{32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h7FC00000,
                            32'hFF800000, 32'hFF800000};
    for (int i = 0; i < 6; i++) begin
      apply(av[i], bv[i], sv[i]);
      vectors++;
      if ({Exception, Result} !== {1'b1, rv[i]}) begin
        miscompares++;
        $display("FAIL special[%0d] %h op%b %h: got exc=%b res=%h, want exc=1 res=%h",
                 i, av[i], sv[i], bv[i], Exception, Result, rv[i]);
      end
    end
  endtask

  function automatic logic [31:0] rand_normal();
    logic [7:0] e;
    if ($urandom_range(0, 15) == 0) e = 8'($urandom_range(248, 254));
    else                            e = 8'($urandom_range(100, 140));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic        s;
    logic [32:0] exp_v;
    for (int i = 0; i < 1000; i++) begin
      a = rand_normal();
      b = rand_normal();
      s = 1'($urandom_range(0, 1));
      if (i == 500) RESET = 1'b1;
      exp_v = (i == 500) ? 33'd0 : ref_add(a, b, s);
      apply(a, b, s);
      RESET = 1'b0;
      vectors++;
      if ({Exception, Result} !== exp_v) begin
        miscompares++;
        $display("FAIL stream[%0d] %h op%b %h: got exc=%b res=%h, want exc=%b res=%h",
                 i, a, s, b, Exception, Result, exp_v[32], exp_v[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_specials();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
